// File: rtl/simple_risc_cpu.sv
// simple_risc_cpu: two-cycle instruction-execute core.
//   clk, reset (async, active-low)
//   s/in        : start pulse and 16-bit instruction, captured in WAIT
//   write_data  : registered datapath result; N/V/Z registered status flags
//   w           : high while waiting for a new instruction
//   mem_addr/mem_cmd/read_data : memory port, inactive in this revision
// Sub-modules: simple_risc_regfile (8x16, 2R/1W) and simple_risc_datapath.

module simple_risc_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr_a,
  input  logic [2:0]  raddr_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b
);
  // Named registers so R0..R7 can be probed directly; deliberately not reset.
  logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;

  always_ff @(posedge clk) begin
    if (we) begin
      case (waddr)
        3'd0: R0 <= wdata;
        3'd1: R1 <= wdata;
        3'd2: R2 <= wdata;
        3'd3: R3 <= wdata;
        3'd4: R4 <= wdata;
        3'd5: R5 <= wdata;
        3'd6: R6 <= wdata;
        default: R7 <= wdata;
      endcase
    end
  end

  function automatic logic [15:0] rd(input logic [2:0] a,
                                     input logic [15:0] r0, r1, r2, r3,
                                     input logic [15:0] r4, r5, r6, r7);
    case (a)
      3'd0: rd = r0;
      3'd1: rd = r1;
      3'd2: rd = r2;
      3'd3: rd = r3;
      3'd4: rd = r4;
      3'd5: rd = r5;
      3'd6: rd = r6;
      default: rd = r7;
    endcase
  endfunction

  // Combinational reads: a same-cycle write is seen only after the edge.
  assign rdata_a = rd(raddr_a, R0, R1, R2, R3, R4, R5, R6, R7);
  assign rdata_b = rd(raddr_b, R0, R1, R2, R3, R4, R5, R6, R7);
endmodule

module simple_risc_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        exec,
  input  logic [15:0] ir,
  output logic [15:0] write_data,
  output logic        N,
  output logic        V,
  output logic        Z
);
  logic [2:0]  op, rn, rd, rm;
  logic [1:0]  aluop, sh;
  logic [15:0] a, rm_val, b, result, sext;
  logic        is_mov_imm, is_mov_reg, is_alu, is_cmp, we, wd_en;

  assign op    = ir[15:13];
  assign aluop = ir[12:11];
  assign rn    = ir[10:8];
  assign rd    = ir[7:5];
  assign sh    = ir[4:3];
  assign rm    = ir[2:0];
  assign sext  = {{8{ir[7]}}, ir[7:0]};

  assign is_mov_imm = (op == 3'b110) && (aluop == 2'b10);
  assign is_mov_reg = (op == 3'b110) && (aluop == 2'b00);
  assign is_alu     = (op == 3'b101);
  assign is_cmp     = is_alu && (aluop == 2'b01);
  assign we    = exec && (is_mov_imm || is_mov_reg || (is_alu && !is_cmp));
  assign wd_en = exec && (is_mov_reg || is_alu);

  simple_risc_regfile REGFILE (
    .clk    (clk),
    .we     (we),
    .waddr  (is_mov_imm ? rn : rd),
    .wdata  (is_mov_imm ? sext : result),
    .raddr_a(rn),
    .raddr_b(rm),
    .rdata_a(a),
    .rdata_b(rm_val)
  );

  always_comb begin
    case (sh)
      2'b01:   b = {rm_val[14:0], 1'b0};
      2'b10:   b = {1'b0, rm_val[15:1]};
      2'b11:   b = {rm_val[15], rm_val[15:1]};
      default: b = rm_val;
    endcase
  end

  always_comb begin
    result = b;  // MOV Rd,Rm{sh} is 0 + sh(Rm)
    if (is_alu) begin
      case (aluop)
        2'b00:   result = a + b;
        2'b01:   result = a - b;
        2'b10:   result = a & b;
        default: result = ~b;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_data <= '0;
      N <= 1'b0;
      V <= 1'b0;
      Z <= 1'b0;
    end else begin
      if (wd_en) write_data <= result;
      if (exec && is_cmp) begin
        N <= result[15];
        Z <= (result == 16'd0);
        // Subtraction overflows only when operand signs differ and the
        // result sign departs from the minuend's.
        V <= (a[15] != b[15]) && (result[15] != a[15]);
      end
    end
  end
endmodule

module simple_risc_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] in,
  input  logic [15:0] read_data,
  output logic [15:0] write_data,
  output logic        N,
  output logic        V,
  output logic        Z,
  output logic        w,
  output logic [8:0]  mem_addr,
  output logic [1:0]  mem_cmd
);
  typedef enum logic {S_WAIT = 1'b0, S_EXEC = 1'b1} state_t;

  state_t      state;
  logic [15:0] ir;
  logic        unused_read;

  assign mem_addr    = '0;
  assign mem_cmd     = 2'b00;
  assign unused_read = ^read_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_WAIT;
      ir    <= '0;
      w     <= 1'b1;
    end else begin
      case (state)
        S_WAIT: if (s) begin
          ir    <= in;
          state <= S_EXEC;
          w     <= 1'b0;
        end
        default: begin
          state <= S_WAIT;
          w     <= 1'b1;
        end
      endcase
    end
  end

  simple_risc_datapath DP (
    .clk       (clk),
    .reset     (reset),
    .exec      (state == S_EXEC),
    .ir        (ir),
    .write_data(write_data),
    .N         (N),
    .V         (V),
    .Z         (Z)
  );
endmodule

// File: tb/tb_simple_risc_cpu.sv
// Self-checking bench for simple_risc_cpu: directed table, chained-shift and
// reset-abort sequences, then random instructions against a reference model.
module tb_simple_risc_cpu;
  logic        clk, reset, s;
  logic [15:0] in, read_data, write_data;
  logic        N, V, Z, w;
  logic [8:0]  mem_addr;
  logic [1:0]  mem_cmd;

  simple_risc_cpu dut (
    .clk(clk), .reset(reset), .s(s), .in(in), .read_data(read_data),
    .write_data(write_data), .N(N), .V(V), .Z(Z), .w(w),
    .mem_addr(mem_addr), .mem_cmd(mem_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model state
  logic [15:0] mregs [8];
  logic [15:0] mwd;
  logic [2:0]  mnvz;  // {N,V,Z}

  typedef struct {
    logic [15:0] instr;
    int          ridx;
    logic [15:0] rval;
    logic [15:0] wd;
    logic [2:0]  nvz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] get_reg(input int i);
    case (i)
      0: return dut.DP.REGFILE.R0;
      1: return dut.DP.REGFILE.R1;
      2: return dut.DP.REGFILE.R2;
      3: return dut.DP.REGFILE.R3;
      4: return dut.DP.REGFILE.R4;
      5: return dut.DP.REGFILE.R5;
      6: return dut.DP.REGFILE.R6;
      default: return dut.DP.REGFILE.R7;
    endcase
  endfunction

  // Architectural effect of one instruction, from the instruction-set rules.
  task automatic model_step(input logic [15:0] instr);
    logic [15:0] a, b;
    logic [31:0] res;
    int diff;
    int op, alu, rn, rd, sh, rm;
    op  = int'(instr >> 13);
    alu = int'((instr >> 11) & 16'h3);
    rn  = int'((instr >> 8) & 16'h7);
    rd  = int'((instr >> 5) & 16'h7);
    sh  = int'((instr >> 3) & 16'h3);
    rm  = int'(instr & 16'h7);
    a = mregs[rn];
    b = mregs[rm];
    if (sh == 1) b = b << 1;
    else if (sh == 2) b = b >> 1;
    else if (sh == 3) b = (b >> 1) | (b & 16'h8000);
    if (op == 6 && alu == 2) begin
      res = 32'(signed'(instr & 16'h00FF) - ((instr & 16'h0080) != 0 ? 256 : 0));
      mregs[rn] = res[15:0];
    end else if (op == 6 && alu == 0) begin
      mregs[rd] = b; mwd = b;
    end else if (op == 5) begin
      case (alu)
        0: begin res = 32'(int'(a) + int'(b)); mregs[rd] = res[15:0]; mwd = res[15:0]; end
        1: begin
          diff = int'($signed(a)) - int'($signed(b));
          res = 32'(diff);
          mwd = res[15:0];
          mnvz = {res[15], (diff > 32767 || diff < -32768), (res[15:0] == 16'd0)};
        end
        2: begin mregs[rd] = a & b; mwd = a & b; end
        default: begin mregs[rd] = ~b; mwd = ~b; end
      endcase
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " write_data"}, write_data, mwd);
    chk({tag, " nvz"}, {N, V, Z}, mnvz);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s R%0d", tag, i), get_reg(i), mregs[i]);
  endtask

  task automatic run_instr(input logic [15:0] instr, input string tag);
    @(negedge clk);
    s = 1'b1; in = instr;
    @(posedge clk); #1;
    s = 1'b0; in = 16'($urandom);  // must not affect the executing instruction
    chk({tag, " w_exec"}, w, 1'b0);
    model_step(instr);
    @(posedge clk); #1;
    chk({tag, " w_done"}, w, 1'b1);
    cmp_model(tag);
  endtask

  vec_t tab_a [13];
  vec_t tab_b [5];

  initial begin
    tab_a = '{
      '{16'hD70A, 7, 16'h000A, 16'h0000, 3'b000},
      '{16'hD0FC, 0, 16'hFFFC, 16'h0000, 3'b000},
      '{16'hA720, 1, 16'h0006, 16'h0006, 3'b000},
      '{16'hD4FC, 4, 16'hFFFC, 16'h0006, 3'b000},
      '{16'hA74C, 2, 16'h0002, 16'h0002, 3'b000},
      '{16'hA177, 3, 16'h000B, 16'h000B, 3'b000},
      '{16'hC093, 4, 16'h0005, 16'h0005, 3'b000},
      '{16'hB8A4, 5, 16'hFFFA, 16'hFFFA, 3'b000},
      '{16'hB8C5, 6, 16'h0005, 16'h0005, 3'b000},
      '{16'hAC03, 4, 16'h0005, 16'hFFFA, 3'b100},
      '{16'hAC04, 3, 16'h000B, 16'h0000, 3'b001},
      '{16'h0000, 0, 16'hFFFC, 16'h0000, 3'b001},
      '{16'hE0E0, 7, 16'h000A, 16'h0000, 3'b001}
    };
    tab_b = '{
      '{16'hD57F, 5, 16'h007F, 16'h3F80, 3'b001},
      '{16'hC0AD, 5, 16'h00FE, 16'h00FE, 3'b001},
      '{16'hC0AD, 5, 16'h01FC, 16'h01FC, 3'b001},
      '{16'hB8A5, 5, 16'hFE03, 16'hFE03, 3'b001},
      '{16'hAD0C, 4, 16'h3F80, 16'h7F03, 3'b010}
    };
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mwd = 16'h0; mnvz = 3'b000;

    reset = 1'b0; s = 1'b0; in = 16'h0; read_data = 16'h0;
    @(negedge clk); @(negedge clk);
    chk("rst write_data", write_data, 16'h0);
    chk("rst nvz", {N, V, Z}, 3'b000);
    chk("rst w", w, 1'b1);
    chk("rst mem", {mem_addr, mem_cmd}, 11'h0);
    reset = 1'b1;

    foreach (tab_a[i]) begin
      run_instr(tab_a[i].instr, $sformatf("tabA%0d", i));
      chk($sformatf("tabA%0d reg", i), get_reg(tab_a[i].ridx), tab_a[i].rval);
      chk($sformatf("tabA%0d wd", i), write_data, tab_a[i].wd);
      chk($sformatf("tabA%0d nvz", i), {N, V, Z}, tab_a[i].nvz);
    end

    // Chained LSL with s held high: one result every two edges.
    run_instr(16'hD47F, "mov_r4_127");
    @(negedge clk);
    s = 1'b1; in = 16'hC08C;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      chk($sformatf("chain%0d w_exec", i), w, 1'b0);
      chk($sformatf("chain%0d old", i), get_reg(4), 16'(127 << (i - 1)));
      model_step(16'hC08C);
      @(posedge clk); #1;
      if (i == 7) s = 1'b0;
      chk($sformatf("chain%0d w_done", i), w, 1'b1);
      chk($sformatf("chain%0d R4", i), get_reg(4), 16'(127 << i));
      chk($sformatf("chain%0d wd", i), write_data, 16'(127 << i));
    end
    cmp_model("chain_end");

    foreach (tab_b[i]) begin
      run_instr(tab_b[i].instr, $sformatf("tabB%0d", i));
      chk($sformatf("tabB%0d reg", i), get_reg(tab_b[i].ridx), tab_b[i].rval);
      chk($sformatf("tabB%0d wd", i), write_data, tab_b[i].wd);
      chk($sformatf("tabB%0d nvz", i), {N, V, Z}, tab_b[i].nvz);
    end

    // Reset during EXEC aborts MOV R7,#99.
    @(negedge clk);
    s = 1'b1; in = 16'hD763;
    @(posedge clk); #1;
    s = 1'b0; reset = 1'b0;
    #1;
    chk("abort w", w, 1'b1);
    chk("abort write_data", write_data, 16'h0);
    chk("abort nvz", {N, V, Z}, 3'b000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mwd = 16'h0; mnvz = 3'b000;
    chk("abort R7", get_reg(7), 16'h000A);
    cmp_model("abort");

    for (int n = 0; n < 200; n++) begin
      logic [31:0] r;
      logic [15:0] instr;
      int kind;
      r = $urandom;
      kind = int'($urandom_range(0, 7));
      instr = r[15:0];
      if (kind == 0) instr = {3'b110, 2'b10, r[10:0]};
      else if (kind == 1) instr = {3'b110, 2'b00, r[10:0]};
      else if (kind <= 5) instr = {3'b101, r[12:0]};
      run_instr(instr, $sformatf("rnd%0d_%h", n, instr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
